demux_frame_sequencer: RTL
==========================

// Module: demux_frame_sequencer
// PURPOSE
//  Upstream feeder for the 1-to-4 channel demux. Accepts one (channel, word) pair per
//  valid/ready handshake and serialises the word bit-by-bit on din while holding the
//  channel select s stable for the whole frame, then inserts an idle gap before the
//  next accept. din/s drive the demux inputs directly; frame_active/frame_done are status.
// PARAMETERS
//  DATA_W      8   bits per word serialised on din; legal 1..32
//  GAP_CYCLES  1   idle cycles after each frame (din=0, s held); legal 0..15
//  MSB_FIRST   0   0: bit 0 sent first; 1: bit DATA_W-1 sent first
// PORTS
//  clk          in   1       single clock, rising edge
//  rst          in   1       asynchronous, active-high reset
//  in_valid     in   1       source has a word
//  in_ready     out  1       block can accept (combinational = IDLE && !rst)
//  in_chan      in   2       destination channel 0..3
//  in_data      in   DATA_W  word to serialise
//  din          out  1       serial bit to demux (registered)
//  s            out  2       demux channel select (registered)
//  frame_active out  1       high while din carries a data bit
//  frame_done   out  1       one-cycle pulse, cycle after last data bit
// BEHAVIOUR
//  Interface: one clock, clk; reset rst asynchronous, active-high (fixed).
//  Reset (async assert, sync-to-clk release): state=IDLE, din=0, s=2'b00,
//   frame_active=0, frame_done=0, shift reg/counters=0; in_ready=0 while rst high.
//  FSM: IDLE -> SHIFT -> GAP -> IDLE (GAP skipped when GAP_CYCLES=0).
//  IDLE: in_ready=1. Accept = in_valid && in_ready at rising edge k: latch in_chan->s,
//   in_data->shift reg, bit_cnt=0, go SHIFT. No accept -> stay IDLE, outputs hold.
//  SHIFT: cycles k+1..k+DATA_W; din = next bit per MSB_FIRST, frame_active=1, s constant.
//   After bit DATA_W-1 -> GAP (or IDLE); bit_cnt width $clog2(DATA_W+1), no wrap used.
//  frame_done=1 exactly in cycle k+DATA_W+1, else 0.
//  GAP: GAP_CYCLES cycles, din=0, frame_active=0, s held; then IDLE.
//  Throughput: back-to-back accepts every 1+DATA_W+GAP_CYCLES cycles.
//  s holds last channel in IDLE/GAP; changes only on accept edge.
//  in_valid while not IDLE: ignored, no state change; source holds in_chan/in_data stable.
//  Reset mid-frame: frame aborted, word discarded, no frame_done, din=0 immediately.
//  Simultaneous rst and accept: reset wins, word not taken.
//  DATA_W=1: single SHIFT cycle; frame_done next cycle.
// STRUCTURE
//  demux_pkg: CHAN_W=2, NUM_CHAN=4, typedef enum {IDLE,SHIFT,GAP} seq_state_t.
//  One sub-module natural: piso_shift (load/shift register, DATA_W, MSB_FIRST,
//   load, shift_en, serial out); FSM, counters and handshake stay in this module.
//  Parameter legality checked by elaboration-time assertion.
// TESTING
//  1 DATA_W=8,G=1: accept chan=2,data=8'hA5 at edge k -> s=2'b10 from k+1; din k+1..k+8 =
//    1,0,1,0,0,1,0,1; frame_active k+1..k+8; frame_done only k+9; in_ready high k+10.
//  2 MSB_FIRST=1, data=8'h81, chan=3 -> din 1,0,0,0,0,0,0,1; s=2'b11 throughout.
//  3 in_valid held high, 4 words chan 0..3 -> accepts every 10 cycles, s steps 00,01,10,11,
//    no lost/duplicated word; in_valid during SHIFT/GAP never accepted.
//  4 rst pulsed at 4th data bit -> din=0, frame_active=0, s=00 same cycle, no frame_done;
//    after release in_ready=1 and next word serialises correctly.
//  5 GAP_CYCLES=0, DATA_W=1: data=1,chan=1 then data=0,chan=2 -> period 2 cycles,
//    frame_done pulses each frame, s changes only on accept edges.
//  6 rst asserted with in_valid=1 on same edge -> nothing accepted, all outputs at reset values.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg: shared channel constants and sequencer state encoding for the demux feeder
package demux_pkg;
    localparam int CHAN_W   = 2;
    localparam int NUM_CHAN = 4;
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} seq_state_t;
endpackage

// File: rtl/piso_shift.sv
// piso_shift: parallel-load shift register whose serial output is registered and returns to 0 when idle
module piso_shift #(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] data,
    output logic              sout
);
    logic [DATA_W-1:0] q;
    // q holds only the bits not yet presented on sout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= '0;
            sout <= 1'b0;
        end else if (load) begin
            sout <= MSB_FIRST != 0 ? data[DATA_W-1] : data[0];
            q    <= MSB_FIRST != 0 ? data << 1 : data >> 1;
        end else if (shift_en) begin
            sout <= MSB_FIRST != 0 ? q[DATA_W-1] : q[0];
            q    <= MSB_FIRST != 0 ? q << 1 : q >> 1;
        end else begin
            sout <= 1'b0;
        end
    end
endmodule

// File: rtl/demux_frame_sequencer.sv
// demux_frame_sequencer: accepts (channel, word) pairs and serialises each word on din
// with a stable channel select s, followed by a fixed idle gap.
module demux_frame_sequencer
    import demux_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 1,
    parameter int MSB_FIRST  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CHAN_W-1:0] in_chan,
    input  logic [DATA_W-1:0] in_data,
    output logic              din,
    output logic [CHAN_W-1:0] s,
    output logic              frame_active,
    output logic              frame_done
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    if (DATA_W < 1 || DATA_W > 32 || GAP_CYCLES < 0 || GAP_CYCLES > 15 ||
        (MSB_FIRST != 0 && MSB_FIRST != 1)) begin : g_bad_param
        $error("demux_frame_sequencer: illegal parameter value");
    end

    seq_state_t       state, state_d;
    logic [CNT_W-1:0] bit_cnt;
    logic [3:0]       gap_cnt;
    logic             accept, last, gap_end, shift_en;

    assign in_ready = state == IDLE && !rst;

    always_comb begin
        accept   = in_valid && in_ready;
        last     = state == SHIFT && bit_cnt == CNT_W'(DATA_W - 1);
        gap_end  = state == GAP && gap_cnt == 4'(GAP_CYCLES - 1);
        shift_en = state == SHIFT && !last;
        state_d  = state;
        unique case (state)
            IDLE:    state_d = accept ? SHIFT : IDLE;
            SHIFT:   state_d = last ? (GAP_CYCLES == 0 ? IDLE : GAP) : SHIFT;
            GAP:     state_d = gap_end ? IDLE : GAP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // frame_done follows the final data bit by one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s            <= '0;
            bit_cnt      <= '0;
            gap_cnt      <= '0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= last;
            gap_cnt    <= state == GAP ? gap_cnt + 4'd1 : 4'd0;
            if (accept) begin
                s            <= in_chan;
                bit_cnt      <= '0;
                frame_active <= 1'b1;
            end else if (state == SHIFT) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (last) frame_active <= 1'b0;
        end
    end

    piso_shift #(.DATA_W(DATA_W), .MSB_FIRST(MSB_FIRST)) u_piso (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .shift_en (shift_en),
        .data     (in_data),
        .sout     (din)
    );
endmodule
